// File: rtl/fetch_queue_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: instruction width,
// the NOP used for faulting fetches, FSM state encoding and the built-in
// ROM image generator.
package fetch_queue_unit_pkg;

   localparam int          INSTR_W   = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_t;

   // Index image: word i holds the value i (bring-up / simulation image).
   function automatic logic [INSTR_W-1:0] index_image_word(input int unsigned idx);
      return idx[INSTR_W-1:0];
   endfunction

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Decode-side handshake bundle: queue head {pc, instr, fault} with valid/ready.
interface fetch_queue_unit_if
   import fetch_queue_unit_pkg::*;
#(
   parameter int XLEN = 64
) ();

   logic               out_valid;
   logic               out_ready;
   logic [XLEN-1:0]    out_pc;
   logic [INSTR_W-1:0] out_instr;
   logic               out_fault;

   modport master (output out_valid, output out_pc, output out_instr, output out_fault,
                   input  out_ready);
   modport slave  (input  out_valid, input  out_pc, input  out_instr, input  out_fault,
                   output out_ready);

endinterface

// File: rtl/fetch_queue_unit_fifo.sv
// Synchronous show-ahead FIFO with flush; push and pop may happen together.
module fetch_queue_unit_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           push_data,
   output logic [WIDTH-1:0]           head_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             do_push;
   logic             do_pop;

   assign full      = (count_reg == CW'(DEPTH));
   assign empty     = (count_reg == '0);
   assign do_pop    = pop & ~empty;
   // A pop in the same cycle makes room for a push into a full FIFO.
   assign do_push   = push & (~full | do_pop);
   assign head_data = mem[rd_ptr_reg];
   assign count     = count_reg;

   // Pointer and occupancy bookkeeping; flush empties the queue in one edge.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         count_reg <= count_reg + {{(CW-1){1'b0}}, do_push} - {{(CW-1){1'b0}}, do_pop};
      end
   end

   // Storage write; contents need no reset because occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr_reg] <= push_data;
   end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: PC generator, synchronous-read ROM, one in-flight
// fetch register and a small queue feeding decode. Redirects flush queued and
// in-flight words; a faulting fetch halts issue until the next redirect.
module fetch_queue_unit
   import fetch_queue_unit_pkg::*;
#(
   parameter int              XLEN       = 64,
   parameter int              IMEM_DEPTH = 256,
   parameter int              FQ_DEPTH   = 4,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter string           IMEM_FILE  = "imem.hex"
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      redirect_valid,
   input  logic [XLEN-1:0]           redirect_pc,
   fetch_queue_unit_if.master        out_bus,
   output logic                      halted,
   output logic [$clog2(FQ_DEPTH):0] fq_count
);

   localparam int IDX_W   = $clog2(IMEM_DEPTH);
   localparam int IDX_HI  = IDX_W + 1;
   localparam int CNT_W   = $clog2(FQ_DEPTH) + 1;
   localparam int ENTRY_W = XLEN + INSTR_W + 1;
   localparam logic [CNT_W:0] DEPTH_LIMIT = (CNT_W + 1)'(FQ_DEPTH);

   fetch_state_t       state_reg, state_next;
   logic [XLEN-1:0]    fetch_pc_reg;
   logic [XLEN-1:0]    inflight_pc_reg;
   logic               inflight_reg;
   logic               inflight_fault_reg;
   logic [INSTR_W-1:0] rom_data_reg;
   logic [INSTR_W-1:0] rom [IMEM_DEPTH];

   logic [XLEN-1:0]    fetch_addr;
   logic [IDX_W-1:0]   rom_idx;
   logic               addr_fault;
   logic               issue;
   logic               push;
   logic               pop;
   logic               out_valid_int;
   logic [CNT_W-1:0]   fifo_count;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CNT_W:0]     occupancy;
   logic [ENTRY_W-1:0] push_entry;
   logic [ENTRY_W-1:0] head_entry;

   // Built-in ROM images selected by name; "nop.hex" is an all-NOP image.
   for (genvar gi = 0; gi < IMEM_DEPTH; gi++) begin : g_rom
      if (IMEM_FILE == "nop.hex") begin : g_nop
         assign rom[gi] = NOP_INSTR;
      end else begin : g_index
         assign rom[gi] = index_image_word(gi);
      end
   end

   assign fetch_addr = redirect_valid ? redirect_pc : fetch_pc_reg;
   assign rom_idx    = fetch_addr[IDX_HI:2];
   assign addr_fault = (fetch_addr[1:0] != 2'b00) || (fetch_addr[XLEN-1:IDX_HI+1] != '0);
   assign occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_reg};

   // A redirect flushes everything this edge, so its target always has room.
   assign issue = ~reset & (redirect_valid |
                  ((state_reg == ST_RUN) & (occupancy < DEPTH_LIMIT) & ~fifo_full));
   assign push  = inflight_reg & ~redirect_valid & ~reset;

   assign out_valid_int = ~fifo_empty & ~redirect_valid & ~reset;
   assign pop           = out_valid_int & out_bus.out_ready;
   assign push_entry    = {inflight_pc_reg,
                           inflight_fault_reg ? NOP_INSTR : rom_data_reg,
                           inflight_fault_reg};

   fetch_queue_unit_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FQ_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .flush     (redirect_valid),
      .push_data (push_entry),
      .head_data (head_entry),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign out_bus.out_valid = out_valid_int;
   assign out_bus.out_pc    = out_valid_int ? head_entry[ENTRY_W-1 -: XLEN] : '0;
   assign out_bus.out_instr = out_valid_int ? head_entry[INSTR_W:1] : '0;
   assign out_bus.out_fault = out_valid_int & head_entry[0];
   assign halted            = (state_reg == ST_HALT);
   assign fq_count          = fifo_count;

   // Run/halt state register.
   always_ff @(posedge clk) begin
      if (reset) state_reg <= ST_RUN;
      else       state_reg <= state_next;
   end

   // Halt on any faulting issue; a redirect resumes unless its target faults.
   always_comb begin
      state_next = state_reg;
      if (redirect_valid)          state_next = addr_fault ? ST_HALT : ST_RUN;
      else if (issue && addr_fault) state_next = ST_HALT;
   end

   // PC generator and in-flight fetch tracking.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_reg       <= RESET_PC;
         inflight_reg       <= 1'b0;
         inflight_pc_reg    <= '0;
         inflight_fault_reg <= 1'b0;
      end else begin
         inflight_reg <= issue;
         if (issue) begin
            fetch_pc_reg       <= fetch_addr + XLEN'(4);
            inflight_pc_reg    <= fetch_addr;
            inflight_fault_reg <= addr_fault;
         end
      end
   end

   // Registered ROM read, enabled only on issue so the word is held until pushed.
   always_ff @(posedge clk) begin
      if (issue) rom_data_reg <= rom[rom_idx];
   end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: directed scenarios plus random redirects and
// back-pressure; a monitor checks every decode transfer against a queue of
// expected entries built from the sequential-fetch rule.
module tb_fetch_queue_unit;
   import fetch_queue_unit_pkg::*;

   localparam int          XLEN       = 64;
   localparam int          IMEM_DEPTH = 32;
   localparam int          FQ_DEPTH   = 4;
   localparam logic [63:0] ROM_BYTES  = 64'd128;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
      logic        fault;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        halted;
   logic [2:0]  fq_count;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   stall_cnt = 0;

   fetch_queue_unit_if #(.XLEN(XLEN)) out_bus ();

   fetch_queue_unit #(
      .XLEN       (XLEN),
      .IMEM_DEPTH (IMEM_DEPTH),
      .FQ_DEPTH   (FQ_DEPTH),
      .RESET_PC   (64'h0),
      .IMEM_FILE  ("imem.hex")
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_bus        (out_bus),
      .halted         (halted),
      .fq_count       (fq_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Expected decode stream from a start PC: sequential words until the first
   // faulting address, which yields one NOP fault entry and ends the stream.
   task automatic load_stream(input logic [63:0] start);
      logic [63:0] pc;
      logic        f;
      exp_q.delete();
      pc = start;
      for (int n = 0; n < 64; n++) begin
         f = (pc % 4 != 0) || (pc >= ROM_BYTES);
         exp_q.push_back('{pc, f ? NOP_INSTR : 32'(pc / 4), f});
         if (f) break;
         pc = pc + 64'd4;
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      load_stream(64'h0);
      tick(1);
      reset = 1'b0;
   endtask

   task automatic do_redirect(input logic [63:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      load_stream(target);
      $display("redirect to %0h", target);
      tick(1);
      redirect_valid = 1'b0;
   endtask

   // Monitor: one line per decode transfer, compared against the expected stream.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            stall_cnt = 0;
         end else begin
            if (redirect_valid) check("redirect_blocks_valid", 64'(out_bus.out_valid), 64'd0);
            if (out_bus.out_valid && out_bus.out_ready) begin
               $display("xfer pc=%0h instr=%h fault=%b", out_bus.out_pc, out_bus.out_instr,
                        out_bus.out_fault);
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL extra_transfer: got pc %0h, required no transfer", out_bus.out_pc);
               end else begin
                  e = exp_q.pop_front();
                  check("xfer_pc", out_bus.out_pc, e.pc);
                  check("xfer_instr", 64'(out_bus.out_instr), 64'(e.instr));
                  check("xfer_fault", 64'(out_bus.out_fault), 64'(e.fault));
                  if (e.fault) check("halted_on_fault", 64'(halted), 64'd1);
               end
            end else if (!out_bus.out_valid) begin
               check("idle_outputs_zero",
                     out_bus.out_pc | 64'(out_bus.out_instr) | 64'(out_bus.out_fault), 64'd0);
            end
            check("count_bound", 64'(fq_count <= 3'd4), 64'd1);
            if (exp_q.size() != 0 && out_bus.out_ready && !redirect_valid && !out_bus.out_valid)
               stall_cnt++;
            else
               stall_cnt = 0;
            if (exp_q.size() != 0 && out_bus.out_ready)
               check("progress", 64'(stall_cnt > 3), 64'd0);
         end
      end
   end

   initial begin
      logic [63:0] target;
      out_bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      // Reset state.
      do_reset();
      reset = 1'b1;
      tick(1);
      check("reset_valid", 64'(out_bus.out_valid), 64'd0);
      check("reset_count", 64'(fq_count), 64'd0);
      check("reset_halted", 64'(halted), 64'd0);
      check("reset_pc", out_bus.out_pc, 64'd0);

      // 1: free-running fetch from RESET_PC.
      do_reset();
      tick(1);
      check("first_gap_valid", 64'(out_bus.out_valid), 64'd0);
      tick(1);
      check("first_valid", 64'(out_bus.out_valid), 64'd1);
      check("first_pc", out_bus.out_pc, 64'd0);
      tick(10);

      // 2: back-pressure saturates the queue, then drains in order.
      out_bus.out_ready = 1'b0;
      do_reset();
      tick(10);
      check("sat_count", 64'(fq_count), 64'd4);
      check("sat_head_pc", out_bus.out_pc, 64'd0);
      out_bus.out_ready = 1'b1;
      tick(8);

      // 3: redirect with three queued entries.
      out_bus.out_ready = 1'b0;
      do_reset();
      tick(4);
      check("three_queued", 64'(fq_count), 64'd3);
      do_redirect(64'h20);
      check("flush_count", 64'(fq_count), 64'd0);
      check("flush_valid", 64'(out_bus.out_valid), 64'd0);
      tick(1);
      check("target_valid", 64'(out_bus.out_valid), 64'd1);
      check("target_pc", out_bus.out_pc, 64'h20);
      check("target_instr", 64'(out_bus.out_instr), 64'd8);
      out_bus.out_ready = 1'b1;
      tick(32);

      // 4: redirect to a misaligned PC halts after one fault entry.
      do_redirect(64'h22);
      tick(8);
      check("misalign_halted", 64'(halted), 64'd1);
      check("misalign_quiet", 64'(out_bus.out_valid), 64'd0);
      do_redirect(64'h08);
      tick(3);
      check("resume_halted", 64'(halted), 64'd0);
      tick(32);

      // 5: run off the ROM end, then resume.
      do_redirect(64'h70);
      tick(10);
      check("rom_end_halted", 64'(halted), 64'd1);
      check("rom_end_quiet", 64'(out_bus.out_valid), 64'd0);
      do_redirect(64'h60);
      tick(1);
      check("resume_pc", out_bus.out_pc, 64'h60);
      tick(12);

      // 6: reset with a loaded queue and an in-flight fetch.
      out_bus.out_ready = 1'b0;
      do_redirect(64'h0);
      tick(3);
      do_reset();
      check("rst_flush_valid", 64'(out_bus.out_valid), 64'd0);
      check("rst_flush_count", 64'(fq_count), 64'd0);
      check("rst_flush_halted", 64'(halted), 64'd0);
      out_bus.out_ready = 1'b1;
      tick(2);
      check("restart_pc", out_bus.out_pc, 64'd0);
      tick(4);

      // Random back-pressure and redirects.
      for (int i = 0; i < 400; i++) begin
         out_bus.out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) begin
            case ($urandom_range(0, 9))
               0:       target = 64'($urandom_range(0, 40)) * 64'd4 + 64'd2;
               1:       target = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3)) * 64'd4;
               2:       target = 64'($urandom_range(32, 64)) * 64'd4;
               default: target = 64'($urandom_range(0, 31)) * 64'd4;
            endcase
            do_redirect(target);
         end else begin
            tick(1);
         end
      end
      out_bus.out_ready = 1'b1;
      tick(50);
      check("drain_complete", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
